// File: rtl/gc_poll_ctrl.sv
// Polls a GameCube controller on the single-wire poll line and decodes its 64-bit reply.
// report_valid follows the last synchronized reply rising edge by one cycle; no backpressure, strobes are one-shot.
module gc_poll_ctrl #(
    parameter int BIT_CYCLES   = 400,
    parameter int SHORT_CYCLES = 100,
    parameter int LONG_CYCLES  = 300,
    parameter int PERIOD       = 600000,
    parameter int RESP_TIMEOUT = 20000,
    parameter int BIT_TIMEOUT  = 800
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        enable,
    input  logic        rumble,
    inout  wire         poll,
    output logic [63:0] report,
    output logic        report_valid,
    output logic        busy,
    output logic        err_timeout,
    output logic [7:0]  err_count
);

    localparam int MAXC = (PERIOD > RESP_TIMEOUT) ? PERIOD : RESP_TIMEOUT;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] C_BIT_M1 = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] C_SHORT  = CW'(SHORT_CYCLES);
    localparam logic [CW-1:0] C_LONG   = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] C_PER_M1 = CW'(PERIOD - 1);
    localparam logic [CW-1:0] C_RESP   = CW'(RESP_TIMEOUT);
    localparam logic [CW-1:0] C_BITTO  = CW'(BIT_TIMEOUT);
    localparam logic [9:0]    HALF_BIT = 10'(BIT_CYCLES / 2);

    typedef enum logic [3:0] {
        IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_LOW, RX_HIGH, DONE, ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    idx_q, idx_d;
    logic          rumble_q, rumble_d;
    logic [63:0]   shreg_q, shreg_d;
    logic [9:0]    lowcnt_q, lowcnt_d;
    logic [63:0]   report_q, report_d;
    logic [7:0]    errcnt_q, errcnt_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;

    logic [23:0]   cmd;
    logic [4:0]    tx_sel;
    logic          tx_bit;
    logic [CW-1:0] lo_len;
    logic          fall, rise, rx_bit;
    logic          drv_en, drv_val;

    assign cmd    = {8'h40, 8'h03, 7'b0000001, rumble_q};
    assign tx_sel = 5'd23 - idx_q[4:0];
    assign tx_bit = cmd[tx_sel];
    assign lo_len = tx_bit ? C_SHORT : C_LONG;
    assign fall   = prev_q & ~sync2_q;
    assign rise   = ~prev_q & sync2_q;

    always_comb begin
        state_d  = state_q;
        per_d    = (per_q == C_PER_M1) ? '0 : per_q + ONE;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rumble_d = rumble_q;
        shreg_d  = shreg_q;
        lowcnt_d = lowcnt_q;
        report_d = report_q;
        errcnt_d = errcnt_q;
        sync1_d  = poll;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        rx_bit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (per_q == '0 && enable) begin
                    state_d  = TX_LOW;
                    rumble_d = rumble;
                    cnt_d    = '0;
                    idx_d    = '0;
                end
            end
            TX_LOW: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == lo_len - ONE) state_d = TX_HIGH;
            end
            TX_HIGH: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == C_BIT_M1) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 6'd1;
                    state_d = (idx_q == 6'd23) ? TX_STOP : TX_LOW;
                end
            end
            TX_STOP: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == C_BIT_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (fall) begin
                    state_d  = RX_LOW;
                    cnt_d    = ONE;
                    lowcnt_d = 10'd1;
                end else if (cnt_q == C_RESP) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            RX_LOW: begin
                // cnt_q keeps counting from the bit's falling edge; lowcnt_q is the synchronized low width
                if (rise) begin
                    rx_bit  = (lowcnt_q < HALF_BIT);
                    shreg_d = {shreg_q[62:0], rx_bit};
                    cnt_d   = cnt_q + ONE;
                    if (idx_q == 6'd63) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = RX_HIGH;
                    end
                end else if (cnt_q == C_BITTO) begin
                    // a line stuck low would otherwise hold the frame forever
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (lowcnt_q != 10'h3FF) lowcnt_d = lowcnt_q + 10'd1;
                end
            end
            RX_HIGH: begin
                if (fall) begin
                    state_d  = RX_LOW;
                    cnt_d    = ONE;
                    lowcnt_d = 10'd1;
                end else if (cnt_q == C_BITTO) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == DONE) report_d = shreg_d;
        if (state_d == ERR && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            per_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            rumble_q <= 1'b0;
            shreg_q  <= '0;
            lowcnt_q <= '0;
            report_q <= '0;
            errcnt_q <= '0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rumble_q <= rumble_d;
            shreg_q  <= shreg_d;
            lowcnt_q <= lowcnt_d;
            report_q <= report_d;
            errcnt_q <= errcnt_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
        end
    end

    assign drv_en  = state_q inside {TX_LOW, TX_HIGH, TX_STOP};
    assign drv_val = (state_q == TX_HIGH) || (state_q == TX_STOP && cnt_q >= C_SHORT);
    assign poll    = drv_en ? drv_val : 1'bz;

    assign report       = report_q;
    assign report_valid = (state_q == DONE);
    assign err_timeout  = (state_q == ERR);
    assign busy         = state_q inside {TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_LOW, RX_HIGH};
    assign err_count    = errcnt_q;

endmodule

// File: tb/tb_gc_poll_ctrl.sv
// Bench for gc_poll_ctrl: scaled-down timing, pulled-up line, bench-side controller reply model.
module tb_gc_poll_ctrl;

    localparam int B   = 4;
    localparam int SH  = 1;
    localparam int LG  = 3;
    localparam int PER = 150;
    localparam int RT  = 24;
    localparam int BT  = 8;

    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b0;
    logic        enable  = 1'b0;
    logic        rumble  = 1'b0;
    logic        drv     = 1'b0;
    wire         poll;
    logic [63:0] report;
    logic        report_valid, busy, err_timeout;
    logic [7:0]  err_count;

    pullup (poll);
    assign poll = drv ? 1'b0 : 1'bz;

    gc_poll_ctrl #(
        .BIT_CYCLES(B), .SHORT_CYCLES(SH), .LONG_CYCLES(LG),
        .PERIOD(PER), .RESP_TIMEOUT(RT), .BIT_TIMEOUT(BT)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .rumble(rumble), .poll(poll),
        .report(report), .report_valid(report_valid), .busy(busy),
        .err_timeout(err_timeout), .err_count(err_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rv_cnt = 0, rv_cyc = -1, et_cnt = 0, et_cyc = -1;
    logic rv_busy = 1'b1;
    logic [63:0] rv_report = '0;

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (report_valid) begin
            rv_cnt    <= rv_cnt + 1;
            rv_cyc    <= cyc;
            rv_busy   <= busy;
            rv_report <= report;
        end
        if (err_timeout) begin
            et_cnt <= et_cnt + 1;
            et_cyc <= cyc;
        end
    end

    // settle point #2 after the edge that starts cycle n
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge PCLK);
            #2;
        end
    endtask

    task automatic apply_reset(output int L);
        int c;
        @(posedge PCLK);
        #2;
        PRESETn = 1'b0;
        drv     = 1'b0;
        c       = cyc;
        goto(c + 5);
        PRESETn = 1'b1;
        L       = cyc;
    endtask

    // expected line level in cycle t for a frame launched in cycle L (released line reads 1)
    function automatic logic exp_line(input int t, input int L, input logic rum);
        logic [23:0] cmdw;
        int off, k, pos;
        cmdw = {8'h40, 8'h03, 7'b0000001, rum};
        off  = t - (L + 1);
        k    = off / B;
        pos  = off % B;
        if (off < 0 || k >= 25) return 1'b1;
        if (k == 24) return (pos >= SH);
        return (pos >= (cmdw[23-k] ? SH : LG));
    endfunction

    function automatic int next_launch(input int L, input int ready);
        int k;
        k = (ready - L + PER - 1) / PER;
        return L + k * PER;
    endfunction

    task automatic drive_reply(input logic [63:0] data, input int nbits, input int start);
        for (int i = 0; i < nbits; i++) begin
            goto(start + i * B);
            drv = 1'b1;
            goto(start + i * B + (data[63-i] ? SH : LG));
            drv = 1'b0;
        end
        if (nbits == 64) begin
            goto(start + 64 * B);
            drv = 1'b1;
            goto(start + 64 * B + SH);
            drv = 1'b0;
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        enable  = 1'b1;
        goto(5);
        checks++;
        if (poll !== 1'b1) begin errors++; $display("FAIL reset_poll: got %b want 1 (released)", poll); end
        checks++;
        if (report !== 64'h0) begin errors++; $display("FAIL reset_report: got %h want 0", report); end
        checks++;
        if ({report_valid, busy, err_timeout} !== 3'b000)
            begin errors++; $display("FAIL reset_flags: got %b want 000", {report_valid, busy, err_timeout}); end
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_idle();
        int L;
        enable = 1'b0;
        apply_reset(L);
        for (int t = L; t < L + 2 * PER; t++) begin
            goto(t);
            checks++;
            if ({poll, busy} !== 2'b10)
                begin errors++; $display("FAIL idle_cycle%0d: got poll=%b busy=%b want poll=1 busy=0", t - L, poll, busy); end
        end
    endtask

    task automatic test_tx(input logic rum);
        int L, R;
        rumble = rum;
        enable = 1'b1;
        apply_reset(L);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tx_busy_launch: got %b want 0", busy); end
        for (int t = L + 1; t <= L + 25 * B; t++) begin
            goto(t);
            checks++;
            if (poll !== exp_line(t, L, rum) || busy !== 1'b1)
                begin errors++; $display("FAIL tx_wave r%0d off%0d: got poll=%b busy=%b want poll=%b busy=1", rum, t - L, poll, busy, exp_line(t, L, rum)); end
            if (t == L + 5)  rumble = ~rum;
            if (t == L + 20) enable = 1'b0;
        end
        R = L + 1 + 25 * B;
        goto(R);
        checks++;
        if ({poll, busy} !== 2'b11) begin errors++; $display("FAIL tx_release: got poll=%b busy=%b want 1 1", poll, busy); end
        goto(R + RT + 2);
        checks++;
        if (et_cyc !== R + RT + 1) begin errors++; $display("FAIL tx_frame_end: got err at %0d want %0d", et_cyc, R + RT + 1); end
        goto(L + PER + 1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tx_enable_off_relaunch: got busy=%b want 0", busy); end
    endtask

    task automatic test_no_reply();
        int L, R, rv0;
        rumble = 1'($urandom);
        enable = 1'b1;
        apply_reset(L);
        rv0 = rv_cnt;
        R   = L + 1 + 25 * B;
        goto(R + RT);
        checks++;
        if ({busy, err_timeout} !== 2'b10) begin errors++; $display("FAIL noreply_pre: got busy=%b err=%b want 1 0", busy, err_timeout); end
        goto(R + RT + 1);
        checks++;
        if ({busy, err_timeout} !== 2'b01) begin errors++; $display("FAIL noreply_strobe: got busy=%b err=%b want 0 1", busy, err_timeout); end
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL noreply_count: got %0d want 1", err_count); end
        goto(R + RT + 2);
        checks++;
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL noreply_one_cycle: got %b want 0", err_timeout); end
        checks++;
        if (report !== 64'h0 || rv_cnt !== rv0) begin errors++; $display("FAIL noreply_report: got %h strobes=%0d want 0 strobes=%0d", report, rv_cnt, rv0); end
        goto(L + PER);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL noreply_gap: got busy=%b want 0", busy); end
        goto(L + PER + 1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL noreply_relaunch: got busy=%b want 1", busy); end
    endtask

    task automatic test_good_reply(input logic [63:0] data);
        int L, R, G, L2, R2, rv0, et0;
        rumble = 1'($urandom);
        enable = 1'b1;
        apply_reset(L);
        rv0 = rv_cnt;
        et0 = et_cnt;
        R   = L + 1 + 25 * B;
        goto(R);
        drv = 1'b1;
        #1;
        checks++;
        if (poll !== 1'b0) begin errors++; $display("FAIL reply_line_released: got %b want 0", poll); end
        drive_reply(data, 64, R);
        G = R + 63 * B + (data[0] ? SH : LG);
        goto(R + 66 * B);
        checks++;
        if (rv_cnt !== rv0 + 1 || rv_cyc !== G + 3)
            begin errors++; $display("FAIL reply_strobe: got n=%0d at %0d want n=%0d at %0d", rv_cnt - rv0, rv_cyc, 1, G + 3); end
        checks++;
        if (rv_report !== data || report !== data) begin errors++; $display("FAIL reply_report: got %h want %h", rv_report, data); end
        checks++;
        if (rv_busy !== 1'b0) begin errors++; $display("FAIL reply_busy_fall: got %b want 0", rv_busy); end
        checks++;
        if (err_count !== 8'd0 || et_cnt !== et0) begin errors++; $display("FAIL reply_no_err: got %0d want 0", err_count); end
        L2 = next_launch(L, G + 4);
        R2 = L2 + 1 + 25 * B;
        goto(R2 + RT + 2);
        checks++;
        if (et_cyc !== R2 + RT + 1) begin errors++; $display("FAIL reply_next_err: got %0d want %0d", et_cyc, R2 + RT + 1); end
        checks++;
        if (report !== data || err_count !== 8'd1) begin errors++; $display("FAIL reply_kept: got %h cnt=%0d want %h cnt=1", report, err_count, data); end
    endtask

    task automatic test_truncated_saturate();
        int L, R, e, exp_err, rv0;
        logic [63:0] data;
        data   = {$urandom(), $urandom()};
        enable = 1'b1;
        apply_reset(L);
        rv0 = rv_cnt;
        R   = L + 1 + 25 * B;
        drive_reply(data, 40, R);
        e = R + 39 * B + BT + 3;
        goto(e + 1);
        checks++;
        if (et_cyc !== e) begin errors++; $display("FAIL trunc_err_time: got %0d want %0d", et_cyc, e); end
        checks++;
        if (report !== 64'h0 || rv_cnt !== rv0 || err_count !== 8'd1)
            begin errors++; $display("FAIL trunc_state: got rep=%h cnt=%0d want 0 cnt=1", report, err_count); end
        exp_err = 1;
        for (int j = 0; j < 258; j++) begin
            L = next_launch(L, e + 1);
            R = L + 1 + 25 * B;
            e = R + RT + 1;
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            goto(e);
            checks++;
            if (err_timeout !== 1'b1 || err_count !== 8'(exp_err))
                begin errors++; $display("FAIL sat_frame%0d: got err=%b cnt=%0d want 1 %0d", j, err_timeout, err_count, exp_err); end
        end
    endtask

    task automatic test_reset_mid_tx();
        int L, t, P, rv0, et0;
        enable = 1'b1;
        apply_reset(L);
        t = L + 1 + 10 * B + 1;
        goto(t);
        checks++;
        if (poll !== 1'b0) begin errors++; $display("FAIL midrst_bit10: got %b want 0", poll); end
        rv0 = rv_cnt;
        et0 = et_cnt;
        PRESETn = 1'b0;
        goto(t + 1);
        checks++;
        if ({poll, busy} !== 2'b10) begin errors++; $display("FAIL midrst_abort: got poll=%b busy=%b want 1 0", poll, busy); end
        goto(t + 4);
        PRESETn = 1'b1;
        P = t + 4;
        checks++;
        if (busy !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL midrst_release: got busy=%b cnt=%0d want 0 0", busy, err_count); end
        goto(P + 1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_relaunch: got busy=%b want 1", busy); end
        checks++;
        if (rv_cnt !== rv0 || et_cnt !== et0) begin errors++; $display("FAIL midrst_strobes: got rv=%0d et=%0d want %0d %0d", rv_cnt, et_cnt, rv0, et0); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_tx(1'b0);
        test_tx(1'b1);
        test_no_reply();
        test_good_reply(64'h0080_8080_8080_0000);
        test_good_reply({$urandom(), $urandom()});
        test_good_reply({$urandom(), $urandom()});
        test_truncated_saturate();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gc_poll_ctrl.md
# gc_poll_ctrl

Frame-level controller for the single-wire GameCube controller link on `poll`. It periodically launches the 24-bit poll command (0x4003 + rumble byte) plus stop bit, releases the line, then decodes the controller's 64-bit reply by measuring each bit's low time. It publishes the captured report with a one-cycle valid strobe and flags missing or truncated replies. It sits between the raw `poll` pad and the balance/steering logic that consumes the stick and button state.

## Interface
- `BIT_CYCLES`, 400: PCLK cycles per transmitted bit cell.
- `SHORT_CYCLES`, 100: low time of a TX '1' and of the TX stop bit.
- `LONG_CYCLES`, 300: low time of a TX '0'.
- `PERIOD`, 600000: cycles between frame launches.
- `RESP_TIMEOUT`, 20000: max cycles from line release to the first reply falling edge.
- `BIT_TIMEOUT`, 800: max cycles between successive reply falling edges.
- `PCLK` in 1: system clock.
- `PRESETn` in 1: reset, synchronous, active-low.
- `enable` in 1: periodic polling on while high.
- `rumble` in 1: rumble request; sampled at frame launch.
- `poll` inout 1: controller data line.
- `report` out 64: last good reply, MSB = first received bit.
- `report_valid` out 1: one-cycle strobe when `report` updates.
- `busy` out 1: high from frame launch until return to IDLE.
- `err_timeout` out 1: one-cycle strobe on reply timeout.
- `err_count` out 8: saturating count of timeouts.

## Operation
- Command word: {8'h40, 8'h03, 7'b0000001, rumble_q}, sent MSB first. `rumble_q` is `rumble` latched at launch.
- Period counter runs 0..PERIOD-1 and wraps whenever `PRESETn` is high. A frame launches when the counter is 0, `enable`=1 and state=IDLE. Otherwise that slot is skipped.
- States:
  - IDLE: line released (`poll`=Z).
  - TX_LOW: drive 0 for LONG_CYCLES if the bit is '0', SHORT_CYCLES if '1'.
  - TX_HIGH: drive 1 for the remainder of BIT_CYCLES. After bit 23, go to TX_STOP.
  - TX_STOP: drive 0 for SHORT_CYCLES, then 1 for BIT_CYCLES-SHORT_CYCLES, then release.
  - RX_WAIT: line released; wait for a falling edge. Go to ERR after RESP_TIMEOUT cycles.
  - RX_LOW: count low cycles. On the rising edge, decide the bit: low count < BIT_CYCLES/2 gives '1', else '0'. Shift it into `shreg`.
  - RX_HIGH: after bit 63, go to DONE. Otherwise go to RX_LOW on the next falling edge, or to ERR if BIT_TIMEOUT cycles pass since the last falling edge.
  - DONE: load `report` from `shreg`, pulse `report_valid`, go to IDLE. The reply's stop bit is not checked.
  - ERR: pulse `err_timeout`, increment `err_count` (saturates at 255), go to IDLE. `report` is unchanged.
- RX input: `poll` passes through a 2-flop synchronizer before edge detection. Edges are detected on the synchronized value.
- Width rules:
  - RX low counter: 10 bits, saturating.
  - Bit index: 6 bits.
  - TX/RX cell counters: wide enough for max(PERIOD, RESP_TIMEOUT).
- Line driving: `poll` is driven only in the TX_* states and is Z in every other state.

## Timing
- Reset values:
  - `poll`=Z, `report`=0, `report_valid`=0, `busy`=0, `err_timeout`=0, `err_count`=0.
  - Period counter=0, state=IDLE.
- Frame launch on cycle L:
  - `busy` rises at L+1.
  - `poll` is driven low from L+1.
  - Bit k's cell spans L+1+k*BIT_CYCLES .. L+(k+1)*BIT_CYCLES.
  - The stop cell is bit 24, and `poll` is released at L+1+25*BIT_CYCLES (L+10001 with defaults).
- RX adds 2 cycles of synchronizer latency to all edge timing. Timeout counters start in the cycle after release or after the last sampled falling edge.
- After the final rising edge of bit 63 is sampled:
  - `report_valid` pulses 1 cycle later, together with the `report` update.
  - `busy` falls in the same cycle.
- `err_timeout` pulses in the cycle after the limit is reached. `busy` falls with it.
- `enable` deasserted mid-frame: the current frame completes and no new launch occurs.
- `rumble` changing mid-frame has no effect until the next launch.
- `PRESETn` low at any point:
  - `poll` goes Z at the next edge and all state resets.
  - No `report_valid` or `err_timeout` is emitted for the aborted frame.

## Test plan
- Reset and idle:
  - Hold `PRESETn`=0 for 5 cycles -> all outputs at reset values, `poll`=Z.
  - Release with `enable`=0 for 2×PERIOD -> `poll` stays Z, `busy`=0.
- TX waveform, `enable`=1, `rumble`=0:
  - Bit 0 is low 300 / high 100.
  - Bit 1 is low 100 / high 300.
  - Bits 22 and 23 are '1' and '0'.
  - The stop cell is low 100 / high 300, then Z at L+10001.
  - Repeat with `rumble`=1 -> bit 23 is low 100.
- Good reply: a bench model drives 0x0080_8080_8080_0000 as 64 cells (0 = 3µs-equivalent low 300 cycles; 1 = low 100) plus a stop bit -> one `report_valid` strobe, `report`=0x0080808080800000, `err_count`=0.
- No reply: the model stays silent -> `err_timeout` pulses once RESP_TIMEOUT+1 cycles after release, `err_count`=1, `report` unchanged, next frame launches PERIOD after the previous launch.
- Truncated reply: the model stops after 40 bits -> `err_timeout` fires BIT_TIMEOUT after the 40th falling edge. Run 300 such frames -> `err_count` saturates at 255.
- Reset mid-TX: pull `PRESETn` low during bit 10 -> `poll`=Z next cycle, `busy`=0, no strobes. After release, the first launch occurs when the period counter wraps to 0.
